score_overlay: RTL and testbench

SCORE_OVERLAY -- requirements
Module: score_overlay

---
 rtl/breakout_pkg.sv | 48 ++++
 rtl/digit_font.sv | 16 +
 rtl/score_overlay.sv | 122 ++++++++++++
 tb/tb_score_overlay.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: game phase encoding, brick count, 8x16 digit font
// and the BCD increment helper used by the score counter.
package breakout_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } game_state_t;

    localparam int BRICK_NUM   = 50;
    localparam int FONT_ROWS   = 16;
    localparam int FONT_DIGITS = 10;

    // Rows 0..15 of each digit; bit 7 is the leftmost pixel.
    localparam logic [7:0] FONT [0:FONT_DIGITS*FONT_ROWS-1] = '{
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hCE, 8'hDE, 8'hF6, 8'hE6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC6, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'h06, 8'h06, 8'h3C, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hCC, 8'hFE, 8'h0C, 8'h0C, 8'h0C, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hFE, 8'hC0, 8'hC0, 8'hC0, 8'hFC, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h38, 8'h60, 8'hC0, 8'hC0, 8'hFC, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hFE, 8'hC6, 8'h06, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7E, 8'h06, 8'h06, 8'h06, 8'h0C, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Three-digit BCD +1 with ripple carry; callers never pass 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] value);
        logic [11:0] result;
        result = value;
        if (value[3:0] != 4'd9) begin
            result[3:0] = value[3:0] + 4'd1;
        end else begin
            result[3:0] = 4'd0;
            if (value[7:4] != 4'd9) begin
                result[7:4] = value[7:4] + 4'd1;
            end else begin
                result[7:4]  = 4'd0;
                result[11:8] = value[11:8] + 4'd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_font.sv
// Combinational glyph lookup: one 8-pixel row of a decimal digit.
module digit_font
    import breakout_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] row,
    output logic [7:0] bitmap
);

    logic [7:0] index;

    assign index  = {digit, row};
    // Non-decimal codes render blank rather than reading past the table.
    assign bitmap = (digit <= 4'd9) ? FONT[index] : 8'h00;

endmodule

// File: rtl/score_overlay.sv
// Breakout score: counts rising brick-collision bits, drains them one per cycle
// into a saturating 3-digit BCD score, and draws the score as an RGB565 overlay.
module score_overlay
    import breakout_pkg::*;
#(
    parameter int          ORIGIN_X = 560,
    parameter int          ORIGIN_Y = 8,
    parameter logic [15:0] FG_COLOR = 16'hFFFF
) (
    input  logic                 vga_clk,
    input  logic                 sys_rst,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    input  logic [BRICK_NUM-1:0] brick_collision,
    input  logic [1:0]           game_state,
    input  logic                 game_reset,
    output logic [15:0]          pix_data,
    output logic [11:0]          score_bcd,
    output logic                 score_sat
);

    logic [BRICK_NUM-1:0] prev_coll_reg;
    logic [BRICK_NUM-1:0] new_hits;
    logic [5:0]           hit_sum;
    logic [5:0]           hit_cnt;
    logic [5:0]           pending_reg, pending_next;
    logic [6:0]           pending_sum;
    logic [11:0]          score_reg, score_next;
    logic                 sat_reg, sat_next;
    logic [2:0]           digit_nine;
    logic                 score_at_max;
    logic [15:0]          pix_reg, pix_next;

    assign new_hits = brick_collision & ~prev_coll_reg;

    always_comb begin
        hit_sum = '0;
        for (int i = 0; i < BRICK_NUM; i++) begin
            hit_sum = hit_sum + 6'(new_hits[i]);
        end
    end

    assign hit_cnt = (game_state == PLAY && !game_reset) ? hit_sum : 6'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_nine
            assign digit_nine[gi] = (score_reg[gi*4 +: 4] == 4'd9);
        end
    endgenerate

    assign score_at_max = &digit_nine;

    always_comb begin
        // Widened so pending + 50 new hits cannot wrap before clamping.
        pending_sum  = {1'b0, pending_reg} + {1'b0, hit_cnt} - {6'd0, pending_reg != 6'd0};
        pending_next = (pending_sum > 7'd63) ? 6'd63 : pending_sum[5:0];
        score_next   = score_reg;
        if (pending_reg != 6'd0 && !score_at_max) begin
            score_next = bcd_inc(score_reg);
        end
        if (game_reset) begin
            pending_next = 6'd0;
            score_next   = 12'h000;
        end
    end

    assign sat_next = (score_next == 12'h999);

    // Pixel path: offsets wrap to large values left of / above the field.
    logic [10:0] dx, dy;
    logic        in_field;
    logic [1:0]  glyph;
    logic [3:0]  glyph_digit;
    logic [7:0]  glyph_bits;
    logic        lit;

    assign dx       = {1'b0, pix_x} - 11'(ORIGIN_X);
    assign dy       = {1'b0, pix_y} - 11'(ORIGIN_Y);
    assign in_field = (dx < 11'd24) && (dy < 11'd16);
    assign glyph    = dx[4:3];

    always_comb begin
        glyph_digit = 4'd0;
        case (glyph)
            2'd0:    glyph_digit = score_reg[11:8];
            2'd1:    glyph_digit = score_reg[7:4];
            2'd2:    glyph_digit = score_reg[3:0];
            default: glyph_digit = 4'd0;
        endcase
    end

    digit_font u_font (
        .digit  (glyph_digit),
        .row    (dy[3:0]),
        .bitmap (glyph_bits)
    );

    assign lit      = glyph_bits[3'd7 - dx[2:0]];
    assign pix_next = (in_field && lit) ? FG_COLOR : 16'h0000;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            prev_coll_reg <= '0;
            pending_reg   <= 6'd0;
            score_reg     <= 12'h000;
            sat_reg       <= 1'b0;
            pix_reg       <= 16'h0000;
        end else begin
            prev_coll_reg <= brick_collision;
            pending_reg   <= pending_next;
            score_reg     <= score_next;
            sat_reg       <= sat_next;
            pix_reg       <= pix_next;
        end
    end

    assign score_bcd = score_reg;
    assign score_sat = sat_reg;
    assign pix_data  = pix_reg;

endmodule

// File: tb/tb_score_overlay.sv
// Bench for score_overlay: directed scenarios plus random traffic, every cycle
// checked against an integer-level model of score, pending hits and pixels.
module tb_score_overlay;
    import breakout_pkg::*;

    logic        vga_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [49:0] brick_collision = '0;
    logic [1:0]  game_state = 2'd0;
    logic        game_reset = 1'b0;
    logic [15:0] pix_data;
    logic [11:0] score_bcd;
    logic        score_sat;

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_score = 0;
    int          m_pend = 0;
    logic [49:0] m_prev = '0;

    always #5 vga_clk = ~vga_clk;

    score_overlay dut (
        .vga_clk         (vga_clk),
        .sys_rst         (sys_rst),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .brick_collision (brick_collision),
        .game_state      (game_state),
        .game_reset      (game_reset),
        .pix_data        (pix_data),
        .score_bcd       (score_bcd),
        .score_sat       (score_sat)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int s);
        return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10));
    endfunction

    function automatic logic [15:0] pix_model(input int x, input int y, input int s);
        int         g;
        int         d;
        logic [7:0] rowbits;
        if (x < 560 || x > 583 || y < 8 || y > 23) return 16'h0000;
        g = (x - 560) / 8;
        d = (g == 0) ? s / 100 : (g == 1) ? (s / 10) % 10 : s % 10;
        rowbits = FONT[d * 16 + (y - 8)];
        return rowbits[7 - ((x - 560) % 8)] ? 16'hFFFF : 16'h0000;
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        logic [15:0] exp_pix;
        int          hits;
        int          old;
        @(posedge vga_clk);
        exp_pix = pix_model(int'(pix_x), int'(pix_y), m_score);
        hits = 0;
        if (game_state == 2'd1 && !game_reset) begin
            for (int i = 0; i < 50; i++) begin
                if (brick_collision[i] && !m_prev[i]) hits++;
            end
        end
        old = m_pend;
        if (game_reset) begin
            m_score = 0;
            m_pend  = 0;
        end else begin
            if (old > 0 && m_score < 999) m_score++;
            m_pend = old + hits - ((old > 0) ? 1 : 0);
            if (m_pend > 63) m_pend = 63;
        end
        m_prev = brick_collision;
        #1;
        check_val("score", 32'(score_bcd), 32'(to_bcd(m_score)));
        check_val("sat", 32'(score_sat), 32'(m_score == 999));
        check_val("pix", 32'(pix_data), 32'(exp_pix));
        check_val("pend", 32'(dut.pending_reg), 32'(m_pend));
    endtask

    task automatic new_round();
        brick_collision = '0;
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;

        repeat (2) @(posedge vga_clk);
        #1;
        check_val("rst_score", 32'(score_bcd), 32'h000);
        check_val("rst_sat", 32'(score_sat), 32'd0);
        check_val("rst_pix", 32'(pix_data), 32'h0000);
        check_val("rst_pend", 32'(dut.pending_reg), 32'd0);
        sys_rst = 1'b0;
        game_state = PLAY;

        // Single-cycle pulse on bit 7
        new_round();
        brick_collision[7] = 1'b1;
        step();
        check_val("p7_pend", 32'(dut.pending_reg), 32'd1);
        check_val("p7_score0", 32'(score_bcd), 32'h000);
        brick_collision = '0;
        step();
        check_val("p7_score1", 32'(score_bcd), 32'h001);

        // Held bit counts once
        new_round();
        brick_collision[3] = 1'b1;
        repeat (200) step();
        check_val("hold_score", 32'(score_bcd), 32'h001);
        brick_collision = '0;
        step();

        // Three simultaneous rises
        new_round();
        brick_collision[0]  = 1'b1;
        brick_collision[20] = 1'b1;
        brick_collision[49] = 1'b1;
        step();
        check_val("tri_pend", 32'(dut.pending_reg), 32'd3);
        check_val("tri_s0", 32'(score_bcd), 32'h000);
        step();
        check_val("tri_s1", 32'(score_bcd), 32'h001);
        step();
        check_val("tri_s2", 32'(score_bcd), 32'h002);
        step();
        check_val("tri_s3", 32'(score_bcd), 32'h003);
        check_val("tri_pend0", 32'(dut.pending_reg), 32'd0);
        brick_collision = '0;
        step();

        // game_reset mid-drain at score 42 / pending 5
        new_round();
        brick_collision = (50'd1 << 47) - 50'd1;
        step();
        repeat (42) step();
        check_val("gr_score42", 32'(score_bcd), 32'h042);
        check_val("gr_pend5", 32'(dut.pending_reg), 32'd5);
        game_reset = 1'b1;
        step();
        check_val("gr_score0", 32'(score_bcd), 32'h000);
        check_val("gr_pend0", 32'(dut.pending_reg), 32'd0);
        game_reset = 1'b0;
        repeat (5) step();
        check_val("gr_nocount", 32'(score_bcd), 32'h000);
        brick_collision = '0;
        step();

        // Climb to 998, then saturate at 999
        new_round();
        guard = 0;
        while (m_score + m_pend < 998 && guard < 5000) begin
            k = 998 - m_score - m_pend;
            if (k > 10) k = 10;
            if (m_pend < 20) brick_collision = (50'd1 << k) - 50'd1;
            else brick_collision = '0;
            step();
            brick_collision = '0;
            step();
            guard++;
        end
        repeat (70) step();
        check_val("sat_998", 32'(score_bcd), 32'h998);
        for (int j = 0; j < 3; j++) begin
            brick_collision[j] = 1'b1;
            step();
            brick_collision = '0;
            step();
        end
        repeat (5) step();
        check_val("sat_999", 32'(score_bcd), 32'h999);
        check_val("sat_flag", 32'(score_sat), 32'd1);
        check_val("sat_pend0", 32'(dut.pending_reg), 32'd0);

        // Glyph sweep over '000'
        new_round();
        for (int r = 0; r < 16; r++) begin
            for (int x = 559; x <= 584; x++) begin
                pix_x = 10'(x);
                pix_y = 10'(8 + r);
                step();
            end
        end
        pix_x = 10'd559; pix_y = 10'd8;
        step();
        check_val("pix_left", 32'(pix_data), 32'h0000);
        pix_x = 10'd584;
        step();
        check_val("pix_right", 32'(pix_data), 32'h0000);

        // Asynchronous reset mid-drain; held bits count again afterwards
        new_round();
        pix_x = 10'd579; pix_y = 10'd12;
        brick_collision = 50'h3FF;
        step();
        step();
        step();
        check_val("ar_lit", 32'(pix_data), 32'hFFFF);
        #1 sys_rst = 1'b1;
        #1;
        check_val("ar_score", 32'(score_bcd), 32'h000);
        check_val("ar_pend", 32'(dut.pending_reg), 32'd0);
        check_val("ar_pix", 32'(pix_data), 32'h0000);
        check_val("ar_sat", 32'(score_sat), 32'd0);
        m_score = 0; m_pend = 0; m_prev = '0;
        @(posedge vga_clk);
        #1 sys_rst = 1'b0;
        step();
        check_val("ar_recount", 32'(dut.pending_reg), 32'd10);
        repeat (12) step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            game_state = ($urandom_range(0, 9) < 7) ? 2'd1 : 2'($urandom_range(0, 3));
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 7) == 0) brick_collision[i] = ~brick_collision[i];
            end
            game_reset = ($urandom_range(0, 99) == 0);
            pix_x = 10'($urandom_range(550, 590));
            pix_y = 10'($urandom_range(0, 30));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
